// File: rtl/cpack_word_decoder.sv
// C-Pack word decoder: rebuilds 32-bit words from pre-parsed codes and a FIFO
// dictionary that is kept in lockstep with the compressor's dictionary.
module cpack_word_decoder #(
    parameter int DICT_DEPTH = 16,
    parameter int IDX_W      = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_type,
    input  logic [IDX_W-1:0] i_index,
    input  logic [31:0]      i_payload,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_word,
    output logic             o_err
);
    localparam logic [IDX_W:0] CNT_FULL = (IDX_W + 1)'(DICT_DEPTH);

    logic [31:0]      r_dict [DICT_DEPTH];
    logic [IDX_W-1:0] r_wr_ptr;
    logic [IDX_W:0]   r_count;
    logic             r_valid;
    logic [31:0]      r_word;
    logic             r_err;

    logic             w_accept;
    logic             w_hit;
    logic [31:0]      w_entry;
    logic [31:0]      w_decoded;
    logic             w_uses_dict;
    logic             w_push_type;
    logic             w_illegal;
    logic             w_err;
    logic             w_push;

    assign o_ready  = ~r_valid | i_ready;
    assign o_valid  = r_valid;
    assign o_word   = r_word;
    assign o_err    = r_err;

    assign w_accept = i_valid & o_ready;
    // Index validity uses the count before this beat's own push.
    assign w_hit    = {1'b0, i_index} < r_count;
    assign w_entry  = w_hit ? r_dict[i_index] : '0;

    always_comb begin
        w_decoded   = '0;
        w_uses_dict = 1'b0;
        w_push_type = 1'b0;
        w_illegal   = 1'b0;
        case (i_type)
            3'd0: w_decoded = '0;
            3'd1: begin
                w_decoded   = i_payload;
                w_push_type = 1'b1;
            end
            3'd2: begin
                w_decoded   = w_entry;
                w_uses_dict = 1'b1;
            end
            3'd3: begin
                w_decoded   = {w_entry[31:16], i_payload[15:0]};
                w_uses_dict = 1'b1;
                w_push_type = 1'b1;
            end
            3'd4: w_decoded = {24'h0, i_payload[7:0]};
            3'd5: begin
                w_decoded   = {w_entry[31:8], i_payload[7:0]};
                w_uses_dict = 1'b1;
                w_push_type = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_err  = w_illegal | (w_uses_dict & ~w_hit);
    // Flush discards the push of a coincident beat but still lets it decode.
    assign w_push = w_accept & w_push_type & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid  <= 1'b0;
            r_word   <= '0;
            r_err    <= 1'b0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_word  <= w_decoded;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end

            if (i_flush) begin
                r_err    <= 1'b0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_accept & w_err) begin
                    r_err <= 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (r_count != CNT_FULL) begin
                        r_count <= r_count + 1'b1;
                    end
                end
            end
        end
    end

    // Entry contents survive flush and reset; count alone governs visibility.
    always_ff @(posedge i_clk) begin
        if (w_push & ~i_reset) begin
            r_dict[r_wr_ptr] <= w_decoded;
        end
    end
endmodule

// File: tb/tb_cpack_word_decoder.sv
// Bench for cpack_word_decoder: directed cases with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_cpack_word_decoder;
    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready_dut;
    logic [2:0]  typ;
    logic [3:0]  idx;
    logic [31:0] payload;
    logic        out_valid;
    logic        ds_ready;
    logic [31:0] word;
    logic        err;

    int unsigned tests = 0;
    int unsigned fails = 0;

    cpack_word_decoder #(.DICT_DEPTH(16), .IDX_W(4)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_flush   (flush),
        .i_valid   (in_valid),
        .o_ready   (out_ready_dut),
        .i_type    (typ),
        .i_index   (idx),
        .i_payload (payload),
        .o_valid   (out_valid),
        .i_ready   (ds_ready),
        .o_word    (word),
        .o_err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: pushes-since-flush counter gives slot and fill level.
    logic [31:0] m_dict [16];
    int unsigned m_pushes = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_word = '0;
    logic        m_err = 1'b0;

    always @(posedge clk) begin
        int unsigned fill;
        logic        acc;
        logic [31:0] e;
        logic [31:0] dec;
        logic        bad;
        if (reset) begin
            m_valid  = 1'b0;
            m_word   = '0;
            m_err    = 1'b0;
            m_pushes = 0;
        end else begin
            fill = (m_pushes < 16) ? m_pushes : 16;
            acc  = in_valid && (!m_valid || ds_ready);
            e    = (int'(idx) < fill) ? m_dict[idx] : 32'h0;
            bad  = 1'b0;
            dec  = 32'h0;
            if ((typ == 2 || typ == 3 || typ == 5) && int'(idx) >= fill) bad = 1'b1;
            if (typ >= 6) bad = 1'b1;
            case (typ)
                1: dec = payload;
                2: dec = e;
                3: dec = {e[31:16], payload[15:0]};
                4: dec = {24'h0, payload[7:0]};
                5: dec = {e[31:8], payload[7:0]};
                default: dec = 32'h0;
            endcase
            if (acc) begin
                m_valid = 1'b1;
                m_word  = dec;
            end else if (ds_ready) begin
                m_valid = 1'b0;
            end
            if (flush) begin
                m_pushes = 0;
                m_err    = 1'b0;
            end else if (acc) begin
                if (bad) m_err = 1'b1;
                if (typ == 1 || typ == 3 || typ == 5) begin
                    m_dict[m_pushes % 16] = dec;
                    m_pushes++;
                end
            end
        end
    end

    always @(negedge clk) begin
        tests++;
        if (out_ready_dut !== (!m_valid || ds_ready)) begin
            fails++;
            $display("FAIL ready: got %b want %b at %0t", out_ready_dut, !m_valid || ds_ready, $time);
        end
        tests++;
        if (out_valid !== m_valid) begin
            fails++;
            $display("FAIL valid: got %b want %b at %0t", out_valid, m_valid, $time);
        end
        tests++;
        if (err !== m_err) begin
            fails++;
            $display("FAIL err: got %b want %b at %0t", err, m_err, $time);
        end
        if (m_valid) begin
            tests++;
            if (word !== m_word) begin
                fails++;
                $display("FAIL word: got %h want %h at %0t", word, m_word, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic beat(input logic [2:0] t, input logic [3:0] ix, input logic [31:0] p,
                        input logic fl = 1'b0);
        in_valid = 1'b1; ds_ready = 1'b1; flush = fl;
        typ = t; idx = ix; payload = p;
        @(posedge clk); #2;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1; in_valid = 1'b0; ds_ready = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; ds_ready = 1'b1;
        typ = '0; idx = '0; payload = '0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_word", word, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_ready", {31'h0, out_ready_dut}, 32'h1);

        beat(1, 0, 32'hDEADBEEF);  chk("t1_lit", word, 32'hDEADBEEF);
        beat(2, 0, 32'h0);         chk("t2_match", word, 32'hDEADBEEF);
        beat(2, 1, 32'h0);         chk("cnt1_miss", {31'h0, err}, 32'h1);

        do_flush();
        beat(1, 0, 32'h12345678);  chk("lit2", word, 32'h12345678);
        beat(3, 0, 32'h0000ABCD);  chk("mmxx", word, 32'h1234ABCD);
        beat(5, 1, 32'h00000099);  chk("mmmx", word, 32'h1234AB99);
        beat(0, 0, 32'hFFFFFFFF);  chk("zzzz", word, 32'h0);
        beat(4, 0, 32'hFFFFFF5A);  chk("zzzx", word, 32'h0000005A);
        beat(2, 2, 32'h0);         chk("idx2", word, 32'h1234AB99);
        chk("no_err3", {31'h0, err}, 32'h0);
        beat(2, 3, 32'h0);         chk("cnt3_miss", {31'h0, err}, 32'h1);

        do_flush();
        for (int unsigned v = 1; v <= 17; v++) beat(1, 0, v);
        beat(2, 0, 32'h0);         chk("wrap0", word, 32'd17);
        beat(2, 15, 32'h0);        chk("wrap15", word, 32'd16);
        beat(2, 1, 32'h0);         chk("wrap1", word, 32'd2);
        chk("full_noerr", {31'h0, err}, 32'h0);

        do_flush();
        beat(1, 0, 32'h5);
        beat(2, 3, 32'h0);         chk("oob_word", word, 32'h0);
        chk("oob_err", {31'h0, err}, 32'h1);
        beat(1, 0, 32'h7);         chk("err_sticky", {31'h0, err}, 32'h1);
        do_flush();                chk("err_clr", {31'h0, err}, 32'h0);
        beat(6, 0, 32'h1234);      chk("ill_word", word, 32'h0);
        chk("ill_err", {31'h0, err}, 32'h1);

        do_flush();
        beat(1, 0, 32'h111);
        in_valid = 1'b1; ds_ready = 1'b0; typ = 3'd1; payload = 32'h222; idx = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            chk("hold_word", word, 32'h111);
            chk("hold_ready", {31'h0, out_ready_dut}, 32'h0);
        end
        ds_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        chk("release", word, 32'h222);
        beat(2, 1, 32'h0);         chk("no_loss", word, 32'h222);
        beat(2, 2, 32'h0);         chk("no_dup", {31'h0, err}, 32'h1);

        do_flush();
        beat(1, 0, 32'hCAFE0000, 1'b1); chk("flush_beat", word, 32'hCAFE0000);
        beat(2, 0, 32'h0);         chk("flush_nopush", word, 32'h0);
        chk("flush_err", {31'h0, err}, 32'h1);

        do_flush();
        for (int unsigned c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            ds_ready = ($urandom_range(0, 3) != 0);
            typ      = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7))
                                                    : 3'($urandom_range(0, 5));
            idx      = 4'($urandom_range(0, 15));
            payload  = $urandom;
            @(posedge clk); #2;
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #2;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
